// File: rtl/adat_pkg.sv
// Shared types for the ADAT frame path: sample/frame layouts and the playback state.
package adat_pkg;

    localparam int CHANNELS     = 8;
    localparam int SAMPLE_WIDTH = 24;

    typedef logic signed [SAMPLE_WIDTH-1:0] sample_t;
    typedef sample_t [0:CHANNELS-1]         frame_t;

    typedef enum logic {
        PRIME = 1'b0,
        RUN   = 1'b1
    } state_t;

endpackage

// File: rtl/adat_frame_bridge_pulse_sync.sv
// Multi-flop synchroniser followed by a rising-edge detector; emits a one-cycle pulse.
module pulse_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic pulse_o
);

    logic [STAGES-1:0] sync_q;
    logic              last_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            last_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_i};
            last_q <= sync_q[STAGES-1];
        end
    end

    assign pulse_o = sync_q[STAGES-1] & ~last_q;

endmodule

// File: rtl/adat_frame_bridge.sv
// Frame FIFO between ADAT receiver and transmitter: pushes on data_valid rising edges,
// pops the oldest frame onto audio_out on each synchronised data_request rising edge.
module adat_frame_bridge #(
    parameter int CHANNELS     = adat_pkg::CHANNELS,
    parameter int SAMPLE_WIDTH = adat_pkg::SAMPLE_WIDTH,
    parameter int DEPTH        = 4,
    parameter int PRIME_LEVEL  = 2,
    parameter int SYNC_STAGES  = 2,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic signed [SAMPLE_WIDTH-1:0] audio_in [0:CHANNELS-1],
    input  logic                           data_valid,
    input  logic                           data_request,
    output logic signed [SAMPLE_WIDTH-1:0] audio_out [0:CHANNELS-1],
    output logic [$clog2(DEPTH+1)-1:0]     fill,
    output logic                           running,
    output logic [CNT_WIDTH-1:0]           underrun_count,
    output logic [CNT_WIDTH-1:0]           overflow_count
);

    import adat_pkg::state_t;
    import adat_pkg::PRIME;
    import adat_pkg::RUN;

    localparam int FRAME_W = CHANNELS * SAMPLE_WIDTH;
    localparam int FILL_W  = $clog2(DEPTH + 1);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam logic [FILL_W-1:0] FULL_LVL  = FILL_W'(DEPTH);
    localparam logic [FILL_W-1:0] PRIME_LVL = FILL_W'(PRIME_LEVEL);

    logic [FRAME_W-1:0] wr_frame;
    logic [FRAME_W-1:0] mem_q [DEPTH];
    logic [FRAME_W-1:0] out_q;

    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [FILL_W-1:0]    fill_q, fill_d;
    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] underrun_q, overflow_q;
    logic                 dv_q;

    logic we, re, pop, push, underrun, overflow;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
            assign wr_frame[gi*SAMPLE_WIDTH +: SAMPLE_WIDTH] = audio_in[gi];
            assign audio_out[gi] = out_q[gi*SAMPLE_WIDTH +: SAMPLE_WIDTH];
        end
    endgenerate

    assign we = data_valid & ~dv_q;

    pulse_sync #(
        .STAGES (SYNC_STAGES)
    ) u_req_sync (
        .clk     (clk),
        .rst     (rst),
        .async_i (data_request),
        .pulse_o (re)
    );

    // Pop is resolved before push, so a full FIFO can accept a write in the pop cycle.
    always_comb begin
        pop      = re && (state_q == RUN) && (fill_q != '0);
        underrun = re && (state_q == RUN) && (fill_q == '0);
        push     = we && ((fill_q != FULL_LVL) || pop);
        overflow = we && (fill_q == FULL_LVL) && !pop;

        fill_d = fill_q;
        if (push && !pop) begin
            fill_d = fill_q + 1'b1;
        end else if (pop && !push) begin
            fill_d = fill_q - 1'b1;
        end

        state_d = state_q;
        if (state_q == PRIME) begin
            if (fill_q >= PRIME_LVL) begin
                state_d = RUN;
            end
        end else if (underrun) begin
            state_d = PRIME;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_frame;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dv_q       <= data_valid;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fill_q     <= '0;
            state_q    <= PRIME;
            out_q      <= '0;
            underrun_q <= '0;
            overflow_q <= '0;
        end else begin
            dv_q    <= data_valid;
            fill_q  <= fill_d;
            state_q <= state_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (re) begin
                out_q <= pop ? mem_q[rd_ptr_q] : '0;
            end
            if (underrun && (underrun_q != '1)) begin
                underrun_q <= underrun_q + 1'b1;
            end
            if (overflow && (overflow_q != '1)) begin
                overflow_q <= overflow_q + 1'b1;
            end
        end
    end

    assign fill           = fill_q;
    assign running        = (state_q == RUN);
    assign underrun_count = underrun_q;
    assign overflow_count = overflow_q;

endmodule
